// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and Gray-code helpers for the async FIFO
//               read- and write-pointer blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Default FIFO address width (depth = 2**width).
    localparam int c_addr_width_default = 9;

    // Helpers operate on a fixed 32-bit container; callers zero-extend
    // their pointer into it and truncate the result back to pointer width.
    localparam int c_fn_width = 32;

    // Binary to reflected Gray code.
    function automatic logic [c_fn_width-1:0] bin2gray(input logic [c_fn_width-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Reflected Gray code to binary: each binary bit is the XOR of all
    // Gray bits at and above its position.
    function automatic logic [c_fn_width-1:0] gray2bin(input logic [c_fn_width-1:0] gray);
        logic [c_fn_width-1:0] bin;
        bin[c_fn_width-1] = gray[c_fn_width-1];
        for (int i = c_fn_width - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/wr_2_rd_sync.sv
`default_nettype none
// ============================================================================
// Module      : wr_2_rd_sync
// Description : Two-flop synchronizer carrying the Gray-coded write pointer
//               into the read clock domain. Nothing sits between the flops.
// Revision    : 1.0 - initial release
// ============================================================================
module wr_2_rd_sync #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_ptr,
    output logic [WIDTH-1:0] o_ptr_sync
);

    logic [WIDTH-1:0] r_wq1;
    logic [WIDTH-1:0] r_wq2;

    // Metastability chain: first flop may go metastable, second resolves it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wq1 <= '0;
            r_wq2 <= '0;
        end else begin
            r_wq1 <= i_ptr;
            r_wq2 <= r_wq1;
        end
    end

    assign o_ptr_sync = r_wq2;

endmodule : wr_2_rd_sync
`default_nettype wire

// File: rtl/rd_ptr_empty.sv
`default_nettype none
// ============================================================================
// Module      : rd_ptr_empty
// Description : Read-side pointer and status logic of an asynchronous FIFO.
//               Keeps the binary/Gray read pointer, synchronizes the write
//               pointer, and produces registered empty, almost-empty,
//               occupancy and underflow indications.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_ptr_empty
    import fifo_pkg::*;
#(
    parameter int Addr_Width = c_addr_width_default,
    parameter int AE_Thresh  = 4
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  rinc,
    input  logic [Addr_Width:0]   wptr,
    output logic [Addr_Width-1:0] raddr,
    output logic [Addr_Width:0]   rptr,
    output logic                  rempty,
    output logic                  ralmost_empty,
    output logic [Addr_Width:0]   rd_count,
    output logic                  rd_underflow
);

    localparam int c_ptr_w = Addr_Width + 1;

    // Threshold in pointer width; its legal range 0..2**Addr_Width fits.
    localparam logic [c_ptr_w-1:0] c_ae_thresh = c_ptr_w'(AE_Thresh);

    // Synchronized Gray write pointer.
    logic [c_ptr_w-1:0] w_wq2;

    // Registered state.
    logic [c_ptr_w-1:0] r_rbin;
    logic [c_ptr_w-1:0] r_rptr;
    logic               r_rempty;
    logic               r_ralmost_empty;
    logic [c_ptr_w-1:0] r_rd_count;
    logic               r_rd_underflow;

    // Next-state values.
    logic               w_pop;
    logic [c_ptr_w-1:0] w_rbin_next;
    logic [c_ptr_w-1:0] w_rgray_next;
    logic [c_ptr_w-1:0] w_wbin_sync;
    logic [c_ptr_w-1:0] w_count_next;
    logic               w_empty_next;
    logic               w_ae_next;
    logic               w_underflow_next;

    wr_2_rd_sync #(
        .WIDTH (c_ptr_w)
    ) u_wr_2_rd_sync (
        .clk        (rclk),
        .rst        (rrst),
        .i_ptr      (wptr),
        .o_ptr_sync (w_wq2)
    );

    // Next pointer, flags and count: empty/count look at the post-pop pointer
    // so draining the last entry raises rempty on the same edge.
    always_comb begin
        w_pop            = rinc & ~r_rempty;
        w_underflow_next = rinc & r_rempty;
        w_rbin_next      = r_rbin + c_ptr_w'(w_pop);
        w_rgray_next     = c_ptr_w'(bin2gray(c_fn_width'(w_rbin_next)));
        w_wbin_sync      = c_ptr_w'(gray2bin(c_fn_width'(w_wq2)));
        w_count_next     = w_wbin_sync - w_rbin_next;
        w_empty_next     = (w_rgray_next == w_wq2);
        w_ae_next        = (w_count_next <= c_ae_thresh);
    end

    // State register; reset overrides any concurrent read request.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_rbin          <= '0;
            r_rptr          <= '0;
            r_rempty        <= 1'b1;
            r_ralmost_empty <= 1'b1;
            r_rd_count      <= '0;
            r_rd_underflow  <= 1'b0;
        end else begin
            r_rbin          <= w_rbin_next;
            r_rptr          <= w_rgray_next;
            r_rempty        <= w_empty_next;
            r_ralmost_empty <= w_ae_next;
            r_rd_count      <= w_count_next;
            r_rd_underflow  <= w_underflow_next;
        end
    end

    // The memory address is a direct slice of the registered binary pointer,
    // so a pop presents the new address with no extra cycle.
    assign raddr         = r_rbin[Addr_Width-1:0];
    assign rptr          = r_rptr;
    assign rempty        = r_rempty;
    assign ralmost_empty = r_ralmost_empty;
    assign rd_count      = r_rd_count;
    assign rd_underflow  = r_rd_underflow;

endmodule : rd_ptr_empty
`default_nettype wire

// File: tb/tb_rd_ptr_empty.sv
`default_nettype none
// ============================================================================
// Module      : tb_rd_ptr_empty
// Description : Self-checking bench for rd_ptr_empty (Addr_Width=4,
//               AE_Thresh=2) against an integer occupancy model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rd_ptr_empty;

    logic       rclk = 1'b0;
    logic       rrst = 1'b1;
    logic       rinc = 1'b0;
    logic [4:0] wptr = 5'b0;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       ralmost_empty;
    logic [4:0] rd_count;
    logic       rd_underflow;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pointers as plain integers modulo 32.
    int m_rd    = 0;
    int m_wq1   = 0;
    int m_wq2   = 0;
    int m_cnt   = 0;
    bit m_empty = 1'b1;
    bit m_ae    = 1'b1;
    bit m_uf    = 1'b0;
    int wbin    = 0;

    always #5 rclk = ~rclk;

    rd_ptr_empty #(
        .Addr_Width (4),
        .AE_Thresh  (2)
    ) dut (
        .rclk          (rclk),
        .rrst          (rrst),
        .rinc          (rinc),
        .wptr          (wptr),
        .raddr         (raddr),
        .rptr          (rptr),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .rd_count      (rd_count),
        .rd_underflow  (rd_underflow)
    );

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] x;
        x = b[4:0];
        return x ^ (x >> 1);
    endfunction

    function automatic logic [16:0] model_vec();
        logic [4:0] c;
        logic [4:0] r;
        c = m_cnt[4:0];
        r = m_rd[4:0];
        return {m_empty, m_ae, m_uf, c, gray5(m_rd), r[3:0]};
    endfunction

    // Drive one cycle of inputs and advance the reference model.
    task automatic tick(input bit r, input bit inc, input int wb);
        @(negedge rclk);
        rrst = r;
        rinc = inc;
        wbin = wb & 31;
        wptr = gray5(wbin);
        @(posedge rclk);
        if (r) begin
            m_rd = 0; m_wq1 = 0; m_wq2 = 0; m_cnt = 0;
            m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0;
        end else begin
            m_uf = inc && m_empty;
            if (inc && !m_empty) m_rd = (m_rd + 1) & 31;
            m_cnt   = (m_wq2 - m_rd) & 31;
            m_empty = (m_cnt == 0);
            m_ae    = (m_cnt <= 2);
            m_wq2   = m_wq1;
            m_wq1   = wbin;
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 2);   // wptr = 5'b00011
        tick(1'b1, 1'b0, 2);
        n_checks++; if (rempty !== 1'b1) $display("FAIL reset_rempty: got %0b expected 1", rempty); else n_pass++;
        n_checks++; if (rd_count !== 5'd0) $display("FAIL reset_count: got %0d expected 0", rd_count); else n_pass++;
        n_checks++; if (rptr !== 5'd0) $display("FAIL reset_rptr: got %b expected 00000", rptr); else n_pass++;
        n_checks++; if (ralmost_empty !== 1'b1) $display("FAIL reset_ae: got %0b expected 1", ralmost_empty); else n_pass++;
        n_checks++; if (rd_underflow !== 1'b0) $display("FAIL reset_uf: got %0b expected 0", rd_underflow); else n_pass++;
        n_checks++; if (raddr !== 4'd0) $display("FAIL reset_raddr: got %0d expected 0", raddr); else n_pass++;
    endtask

    task automatic test_sync_latency();
        // wptr = Gray(3) set before edge N
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, 3);
            n_checks++;
            if (rempty !== 1'b1 || rd_count !== 5'd0)
                $display("FAIL sync_early%0d: got empty=%0b count=%0d expected empty=1 count=0", i, rempty, rd_count);
            else n_pass++;
        end
        tick(1'b0, 1'b0, 3);
        n_checks++; if (rempty !== 1'b0) $display("FAIL sync_empty: got %0b expected 0", rempty); else n_pass++;
        n_checks++; if (rd_count !== 5'd3) $display("FAIL sync_count: got %0d expected 3", rd_count); else n_pass++;
        n_checks++; if (ralmost_empty !== 1'b0) $display("FAIL sync_ae: got %0b expected 0", ralmost_empty); else n_pass++;
    endtask

    task automatic test_drain();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 3);
            n_checks++;
            if (rd_count !== 5'(2 - i) || ralmost_empty !== 1'b1 || rempty !== (i == 2))
                $display("FAIL drain%0d: got count=%0d ae=%0b empty=%0b expected count=%0d ae=1 empty=%0b",
                         i, rd_count, ralmost_empty, rempty, 2 - i, (i == 2));
            else n_pass++;
            n_checks++;
            if (raddr !== 4'(i + 1))
                $display("FAIL drain_raddr%0d: got %0d expected %0d", i, raddr, i + 1);
            else n_pass++;
        end
    endtask

    task automatic test_underflow();
        tick(1'b0, 1'b1, 3);
        n_checks++; if (rd_underflow !== 1'b1) $display("FAIL uf_pulse: got %0b expected 1", rd_underflow); else n_pass++;
        n_checks++; if (rptr !== 5'b00010) $display("FAIL uf_rptr: got %b expected 00010", rptr); else n_pass++;
        n_checks++;
        if (rd_count !== 5'd0 || rempty !== 1'b1)
            $display("FAIL uf_state: got count=%0d empty=%0b expected count=0 empty=1", rd_count, rempty);
        else n_pass++;
        tick(1'b0, 1'b0, 3);
        n_checks++; if (rd_underflow !== 1'b0) $display("FAIL uf_one_cycle: got %0b expected 0", rd_underflow); else n_pass++;
        n_checks++; if (rptr !== 5'b00010) $display("FAIL uf_rptr_hold: got %b expected 00010", rptr); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [4:0]  prev_rptr;
        logic [4:0]  diff;
        logic [16:0] exp_v;
        bit          saw_wrap;
        int          bad;
        saw_wrap = 1'b0;
        bad      = 0;
        for (int w = 4; w <= 46; w++) begin
            prev_rptr = rptr;
            tick(1'b0, 1'b1, (w > 40) ? 40 : w);
            exp_v = model_vec();
            diff  = prev_rptr ^ rptr;
            if ($countones(diff) > 1 || rd_count > 5'd16) bad++;
            if (prev_rptr == gray5(31) && rptr == gray5(0)) saw_wrap = 1'b1;
            n_checks++;
            if ({rempty, ralmost_empty, rd_underflow, rd_count, rptr, raddr} !== exp_v)
                $display("FAIL wrap_model w=%0d: got %b expected %b", w,
                         {rempty, ralmost_empty, rd_underflow, rd_count, rptr, raddr}, exp_v);
            else n_pass++;
        end
        n_checks++; if (bad != 0) $display("FAIL wrap_gray_step: got %0d bad steps expected 0", bad); else n_pass++;
        n_checks++; if (saw_wrap !== 1'b1) $display("FAIL wrap_31_to_0: got %0b expected 1", saw_wrap); else n_pass++;
        n_checks++; if (rempty !== 1'b1) $display("FAIL wrap_drained: got %0b expected 1", rempty); else n_pass++;
    endtask

    task automatic test_random();
        logic [16:0] exp_v;
        int          wb;
        for (int i = 0; i < 400; i++) begin
            wb = wbin;
            if (($urandom % 2 == 1) && (((wbin - m_rd) & 31) < 16)) wb = (wbin + 1) & 31;
            tick(1'b0, ($urandom % 3) != 0, wb);
            exp_v = model_vec();
            n_checks++;
            if ({rempty, ralmost_empty, rd_underflow, rd_count, rptr, raddr} !== exp_v)
                $display("FAIL random%0d: got %b expected %b", i,
                         {rempty, ralmost_empty, rd_underflow, rd_count, rptr, raddr}, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_drain();
        int          wb5;
        logic [16:0] exp_v;
        for (int i = 0; i < 24; i++) tick(1'b0, 1'b1, wbin);
        wb5 = (wbin + 5) & 31;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, wb5);
        n_checks++; if (rd_count !== 5'd5) $display("FAIL mid_prep_count: got %0d expected 5", rd_count); else n_pass++;
        tick(1'b1, 1'b1, wb5);
        n_checks++;
        if ({rempty, ralmost_empty, rd_underflow, rd_count, rptr, raddr} !== {1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 4'd0})
            $display("FAIL mid_reset: got %b expected %b",
                     {rempty, ralmost_empty, rd_underflow, rd_count, rptr, raddr}, {1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 4'd0});
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, 2);
            exp_v = model_vec();
            n_checks++;
            if ({rempty, ralmost_empty, rd_underflow, rd_count, rptr, raddr} !== exp_v)
                $display("FAIL post_reset%0d: got %b expected %b", i,
                         {rempty, ralmost_empty, rd_underflow, rd_count, rptr, raddr}, exp_v);
            else n_pass++;
            if (i == 1) begin
                n_checks++;
                if (rempty !== 1'b1 || raddr !== 4'd0)
                    $display("FAIL post_reset_early: got empty=%0b raddr=%0d expected empty=1 raddr=0", rempty, raddr);
                else n_pass++;
            end
        end
        n_checks++; if (raddr !== 4'd1) $display("FAIL post_reset_pop: got %0d expected 1", raddr); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sync_latency();
        test_drain();
        test_underflow();
        test_wrap();
        test_random();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_rd_ptr_empty
`default_nettype wire
